id_stage_ctrl: RTL and testbench
================================

ID_STAGE_CTRL -- requirements
Module: id_stage_ctrl

Interface
REQ-001 SHALL have parameter CSR_DRAIN, default 3: cycles a CSR instruction is held in ID before issue (range 1..15).
REQ-002 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port if_valid, input, 1: fetch stage offers an instruction.
REQ-005 SHALL have port if_ready, output, 1: ID accepts the offer this cycle.
REQ-006 SHALL have port if_instr, input, 32: offered instruction word.
REQ-007 SHALL have port if_pc, input, 32: PC of the offered instruction.
REQ-008 SHALL have port flush, input, 1: branch/jump redirect; kill the ID contents.
REQ-009 SHALL have port ex_is_load, input, 1: the instruction currently in EX is a load.
REQ-010 SHALL have port ex_rd, input, 5: destination register of the EX instruction.
REQ-011 SHALL have port id_valid, output, 1: ID presents an issuable instruction to EX.
REQ-012 SHALL have port id_ready, input, 1: EX accepts the ID instruction.
REQ-013 SHALL have ports id_instr (output, 32) and id_pc (output, 32): the held instruction and its PC.
REQ-014 SHALL have port id_imm_src, output, 3: immediate-format select for the immediate extender. Encodings: 000 I, 001 S, 010 B, 011 J, 100 U, 101 CSR-zimm.
REQ-015 SHALL have ports id_illegal (output, 1: unknown opcode) and id_stall (output, 1: load-use or CSR hold active).

Function
REQ-016 SHALL decode id_instr[6:0] as follows:
- 0010011, 0000011, 1100111 -> 000.
- 0100011 -> 001.
- 1100011 -> 010.
- 1101111 -> 011.
- 0110111, 0010111 -> 100.
- 1110011 -> 101 if id_instr[14] is 1, else 000.
- 0110011 -> 000.
- Any other opcode -> 000 with id_illegal=1.
REQ-017 SHALL implement states EMPTY, HOLD, STALL and DRAIN, where DRAIN is present only per REQ-030.
REQ-018 SHALL drive if_ready=1 in EMPTY, and in HOLD when id_valid&&id_ready; otherwise if_ready=0, and it SHALL be 0 whenever flush=1.
REQ-019 SHALL capture if_instr/if_pc on if_valid&&if_ready and move to HOLD; with no capture, HOLD moves to EMPTY on id_valid&&id_ready.
REQ-020 SHALL detect a load-use hazard in HOLD when all of the following hold:
- ex_is_load=1.
- ex_rd!=0.
- ex_rd equals rs1 (instr[19:15]) for opcodes that use rs1, or rs2 (instr[24:20]) for R/S/B types.
REQ-021 SHALL, on a hazard, drive id_valid=0 and id_stall=1 in that same cycle and move to STALL.
REQ-022 SHALL hold STALL for exactly one cycle with id_valid=0 and id_stall=1, then return to HOLD, where the hazard is re-evaluated.
REQ-023 SHALL drive id_valid=1 only in HOLD with no hazard; id_valid SHALL stay asserted with id_instr stable until id_ready.
REQ-024 SHALL give flush top priority: the next state is EMPTY, id_valid=0 in the flush cycle, and a simultaneous if_valid offer is not captured.
REQ-025 SHALL register id_instr, id_pc, id_imm_src and id_illegal with the capture, so they are valid the cycle after acceptance (1-cycle latency).
REQ-026 SHALL, when capture and issue happen in the same cycle (back-to-back), sustain one instruction per cycle without a bubble.

Reset
REQ-027 SHALL, while rst_n=0, asynchronously force the following:
- state=EMPTY.
- id_valid=0, id_stall=0, id_illegal=0.
- id_instr=32'h00000013 (NOP).
- id_pc=0.
- id_imm_src=000.
- drain counter=0.
REQ-028 SHALL, on reset assertion mid-operation (any state), discard the held instruction; the first cycle after deassertion SHALL show if_ready=1.

Configuration
REQ-029 SHALL provide macro ID_CSR_SERIALIZE_EN.
REQ-030 SHALL, with ID_CSR_SERIALIZE_EN defined, behave as follows for a captured instruction with opcode 1110011:
- Enter DRAIN with counter=CSR_DRAIN.
- Drive id_valid=0 and id_stall=1 while in DRAIN.
- Decrement the counter each cycle and enter HOLD when it reaches 0.
- Flush exits DRAIN to EMPTY.
REQ-031 SHALL, with ID_CSR_SERIALIZE_EN undefined, contain no DRAIN state or counter and treat CSR opcodes like any other instruction.

Structure
REQ-032 SHALL take the following from shared package id_ctrl_pkg:
- Opcode localparams.
- The imm_src encodings of REQ-014.
- The state enum.
REQ-033 SHALL put the REQ-016 decode, plus the uses_rs1/uses_rs2 flags, in combinational sub-module id_imm_decode; state, registers and handshake SHALL stay in id_stage_ctrl.

Verification
REQ-034 SHALL cover: offer 0x00A00093 (addi), id_ready=1 -> next cycle id_valid=1, id_imm_src=000, id_pc=offered PC.
REQ-035 SHALL cover: ID holds 0x002081B3 (add x3,x1,x2), ex_is_load=1, ex_rd=2 -> id_valid=0, id_stall=1 for exactly 1 cycle, then issue.
REQ-036 SHALL cover: same as REQ-035 with ex_rd=0 -> no stall, immediate issue.
REQ-037 SHALL cover: flush=1 together with if_valid=1 while in HOLD -> next cycle id_valid=0, state EMPTY, offered word not captured.
REQ-038 SHALL cover: macro defined, offer 0x3402D073 (CSRRWI) -> id_stall=1 for 3 cycles, then id_valid=1 with id_imm_src=101; macro undefined -> issue the next cycle.
REQ-039 SHALL cover: rst_n pulled low while in STALL -> outputs at REQ-027 values immediately, and if_ready=1 on the first cycle after release.

Source files
------------

// File: rtl/id_ctrl_pkg.sv
// Shared opcodes, immediate-format encodings and FSM state type for the ID stage.
// The DRAIN state exists only when ID_CSR_SERIALIZE_EN is defined.
package id_ctrl_pkg;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;
    localparam logic [2:0] IMM_Z = 3'b101;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

`ifdef ID_CSR_SERIALIZE_EN
    typedef enum logic [1:0] {ST_EMPTY, ST_HOLD, ST_STALL, ST_DRAIN} id_state_e;
`else
    typedef enum logic [1:0] {ST_EMPTY, ST_HOLD, ST_STALL} id_state_e;
`endif

endpackage

// File: rtl/id_stage_ctrl_decode.sv
// Combinational opcode decode: immediate format, illegal-opcode flag and
// which source registers the instruction reads (for load-use detection).
module id_imm_decode
    import id_ctrl_pkg::*;
(
    input  logic [31:0] instr,
    output logic [2:0]  imm_src,
    output logic        illegal,
    output logic        uses_rs1,
    output logic        uses_rs2
);

    always_comb begin
        imm_src  = IMM_I;
        illegal  = 1'b0;
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        case (instr[6:0])
            OPC_OP_IMM, OPC_LOAD, OPC_JALR: uses_rs1 = 1'b1;
            OPC_STORE: begin
                imm_src  = IMM_S;
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OPC_BRANCH: begin
                imm_src  = IMM_B;
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OPC_JAL:             imm_src = IMM_J;
            OPC_LUI, OPC_AUIPC:  imm_src = IMM_U;
            OPC_SYSTEM: begin
                // funct3[2] selects the zimm CSR forms; the others read rs1
                imm_src  = instr[14] ? IMM_Z : IMM_I;
                uses_rs1 = ~instr[14];
            end
            OPC_OP: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/id_stage_ctrl.sv
// ID stage control: one-entry instruction holding register with load-use stall,
// flush and optional CSR serialisation (macro ID_CSR_SERIALIZE_EN).
module id_stage_ctrl
    import id_ctrl_pkg::*;
#(
    parameter int unsigned CSR_DRAIN = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_valid,
    output logic        if_ready,
    input  logic [31:0] if_instr,
    input  logic [31:0] if_pc,
    input  logic        flush,
    input  logic        ex_is_load,
    input  logic [4:0]  ex_rd,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [2:0]  id_imm_src,
    output logic        id_illegal,
    output logic        id_stall,
    output logic [1:0]  dbg_state
);

    // Handshakes: a transfer happens on a cycle where valid && ready are both
    // high; valid never depends on ready, and once id_valid is raised the
    // instruction stays stable until accepted or flushed.

    if (CSR_DRAIN < 1 || CSR_DRAIN > 15) begin : g_bad_drain
        $error("CSR_DRAIN must be in 1..15");
    end

    id_state_e   state_q, state_d;
    logic        capture, hazard;
    logic [2:0]  dec_imm_src;
    logic        dec_illegal, dec_uses_rs1, dec_uses_rs2;
    logic        uses_rs1_q, uses_rs2_q;

    // Decode the offered word so the flags are registered alongside it
    id_imm_decode u_decode (
        .instr    (if_instr),
        .imm_src  (dec_imm_src),
        .illegal  (dec_illegal),
        .uses_rs1 (dec_uses_rs1),
        .uses_rs2 (dec_uses_rs2)
    );

    assign hazard = (state_q == ST_HOLD) && ex_is_load && (ex_rd != 5'd0) &&
                    ((uses_rs1_q && (ex_rd == id_instr[19:15])) ||
                     (uses_rs2_q && (ex_rd == id_instr[24:20])));

    assign dbg_state = state_q;

`ifdef ID_CSR_SERIALIZE_EN
    localparam logic [3:0] DRAIN_LOAD = 4'(CSR_DRAIN);
    logic [3:0] drain_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drain_cnt_q <= 4'd0;
        end else if (flush) begin
            drain_cnt_q <= 4'd0;
        end else if (capture && (if_instr[6:0] == OPC_SYSTEM)) begin
            drain_cnt_q <= DRAIN_LOAD;
        end else if ((state_q == ST_DRAIN) && (drain_cnt_q != 4'd0)) begin
            drain_cnt_q <= drain_cnt_q - 4'd1;
        end
    end
`endif

    always_comb begin
        state_d  = state_q;
        id_valid = 1'b0;
        id_stall = 1'b0;
        if_ready = 1'b0;
        capture  = 1'b0;
        case (state_q)
            ST_EMPTY: if_ready = 1'b1;
            ST_HOLD: begin
                if (hazard) begin
                    id_stall = 1'b1;
                    state_d  = ST_STALL;
                end else begin
                    id_valid = 1'b1;
                    if (id_ready) begin
                        if_ready = 1'b1;
                        state_d  = ST_EMPTY;
                    end
                end
            end
            ST_STALL: begin
                id_stall = 1'b1;
                state_d  = ST_HOLD;
            end
`ifdef ID_CSR_SERIALIZE_EN
            ST_DRAIN: begin
                id_stall = 1'b1;
                if (drain_cnt_q <= 4'd1) state_d = ST_HOLD;
            end
`endif
            default: state_d = ST_EMPTY;
        endcase

        if (if_ready && if_valid) begin
            capture = 1'b1;
`ifdef ID_CSR_SERIALIZE_EN
            state_d = (if_instr[6:0] == OPC_SYSTEM) ? ST_DRAIN : ST_HOLD;
`else
            state_d = ST_HOLD;
`endif
        end

        // Redirect wins over everything, including a same-cycle offer
        if (flush) begin
            if_ready = 1'b0;
            id_valid = 1'b0;
            capture  = 1'b0;
            state_d  = ST_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_EMPTY;
            id_instr   <= NOP_INSTR;
            id_pc      <= 32'd0;
            id_imm_src <= IMM_I;
            id_illegal <= 1'b0;
            uses_rs1_q <= 1'b0;
            uses_rs2_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                id_instr   <= if_instr;
                id_pc      <= if_pc;
                id_imm_src <= dec_imm_src;
                id_illegal <= dec_illegal;
                uses_rs1_q <= dec_uses_rs1;
                uses_rs2_q <= dec_uses_rs2;
            end
        end
    end

endmodule

// File: tb/tb_id_stage_ctrl.sv
// Self-checking bench for id_stage_ctrl: directed scenarios plus randomized
// traffic against a transaction-level reference model.
module tb_id_stage_ctrl;

    localparam int CSR_DRAIN = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_valid, if_ready, flush, ex_is_load, id_valid, id_ready;
    logic        id_illegal, id_stall;
    logic [31:0] if_instr, if_pc, id_instr, id_pc;
    logic [4:0]  ex_rd;
    logic [2:0]  id_imm_src;
    logic [1:0]  dbg_state;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    id_stage_ctrl #(.CSR_DRAIN(CSR_DRAIN)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
        .flush(flush), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
        .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc),
        .id_imm_src(id_imm_src), .id_illegal(id_illegal), .id_stall(id_stall),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model helpers ----------------
    function automatic logic [2:0] m_imm(input logic [31:0] ins);
        case (ins[6:0])
            7'h23:        return 3'd1;
            7'h63:        return 3'd2;
            7'h6F:        return 3'd3;
            7'h37, 7'h17: return 3'd4;
            7'h73:        return ins[14] ? 3'd5 : 3'd0;
            default:      return 3'd0;
        endcase
    endfunction

    function automatic logic m_illegal(input logic [31:0] ins);
        return !(ins[6:0] inside {7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h6F,
                                  7'h37, 7'h17, 7'h73, 7'h33});
    endfunction

    function automatic logic m_hazard(input logic [31:0] ins, input logic ld, input logic [4:0] rd);
        logic r1, r2;
        r2 = ins[6:0] inside {7'h33, 7'h23, 7'h63};
        r1 = r2 || (ins[6:0] inside {7'h13, 7'h03, 7'h67}) || (ins[6:0] == 7'h73 && !ins[14]);
        return ld && (rd != 5'd0) && ((r1 && rd == ins[19:15]) || (r2 && rd == ins[24:20]));
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0] ops [12];
        logic [31:0] r;
        ops = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h6F, 7'h37, 7'h17, 7'h73, 7'h33, 7'h7F, 7'h0B};
        r = $urandom();
        r[6:0] = ops[$urandom_range(0, 11)];
        r[19:15] = 5'($urandom_range(0, 3));
        r[24:20] = 5'($urandom_range(0, 3));
        return r;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        if_valid = 1'b0; if_instr = 32'h0; if_pc = 32'h0; flush = 1'b0;
        ex_is_load = 1'b0; ex_rd = 5'd0; id_ready = 1'b0;
    endtask

    task automatic offer(input logic [31:0] ins, input logic [31:0] pc, input logic rdy);
        @(negedge clk);
        if_valid = 1'b1; if_instr = ins; if_pc = pc; id_ready = rdy;
    endtask

    task automatic clear_pipe();
        @(negedge clk);
        idle_inputs();
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        #12;
        n_cmp++;
        if ({if_ready, id_valid, id_stall, id_illegal} !== 4'b1000) begin
            n_err++; $display("FAIL reset_flags: got %b want 1000", {if_ready, id_valid, id_stall, id_illegal});
        end
        n_cmp++;
        if ({id_instr, id_pc, id_imm_src} !== {32'h13, 32'h0, 3'b000}) begin
            n_err++; $display("FAIL reset_regs: got instr=%h pc=%h imm=%b", id_instr, id_pc, id_imm_src);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_addi();
        offer(32'h00A00093, 32'h100, 1'b1);
        #1;
        n_cmp++;
        if (if_ready !== 1'b1) begin n_err++; $display("FAIL addi_accept: if_ready=%b want 1", if_ready); end
        @(negedge clk);
        idle_inputs(); id_ready = 1'b1;
        #1;
        n_cmp++;
        if ({id_valid, id_stall, id_imm_src, id_illegal} !== 6'b10_000_0) begin
            n_err++; $display("FAIL addi_issue: got v/s/imm/ill=%b want 100000", {id_valid, id_stall, id_imm_src, id_illegal});
        end
        n_cmp++;
        if ({id_instr, id_pc} !== {32'h00A00093, 32'h100}) begin
            n_err++; $display("FAIL addi_data: got instr=%h pc=%h want 00a00093/100", id_instr, id_pc);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if ({id_valid, if_ready} !== 2'b01) begin n_err++; $display("FAIL addi_empty: got v/r=%b want 01", {id_valid, if_ready}); end
        idle_inputs();
    endtask

    task automatic test_load_use(input logic [4:0] rd);
        offer(32'h002081B3, 32'h200, 1'b0);
        @(negedge clk);
        if_valid = 1'b0; ex_is_load = 1'b1; ex_rd = rd; id_ready = 1'b1;
        #1;
        if (rd != 5'd0) begin
            n_cmp++;
            if ({id_valid, id_stall} !== 2'b01) begin n_err++; $display("FAIL ldu_detect: got v/s=%b want 01", {id_valid, id_stall}); end
            @(negedge clk);
            ex_is_load = 1'b0;
            #1;
            n_cmp++;
            if ({id_valid, id_stall} !== 2'b01) begin n_err++; $display("FAIL ldu_stall: got v/s=%b want 01", {id_valid, id_stall}); end
            @(negedge clk);
            #1;
        end
        n_cmp++;
        if ({id_valid, id_stall, id_pc} !== {2'b10, 32'h200}) begin
            n_err++; $display("FAIL ldu_issue rd=%0d: got v/s=%b pc=%h want 10/200", rd, {id_valid, id_stall}, id_pc);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        n_cmp++;
        if ({id_valid, if_ready} !== 2'b01) begin n_err++; $display("FAIL ldu_done rd=%0d: got v/r=%b want 01", rd, {id_valid, if_ready}); end
    endtask

    task automatic test_flush();
        offer(32'h00500113, 32'h300, 1'b0);
        @(negedge clk);
        if_valid = 1'b1; if_instr = 32'h00700193; if_pc = 32'h400; flush = 1'b1;
        #1;
        n_cmp++;
        if ({if_ready, id_valid} !== 2'b00) begin n_err++; $display("FAIL flush_cycle: got r/v=%b want 00", {if_ready, id_valid}); end
        @(negedge clk);
        idle_inputs();
        #1;
        n_cmp++;
        if ({if_ready, id_valid, id_stall} !== 3'b100) begin n_err++; $display("FAIL flush_empty: got r/v/s=%b want 100", {if_ready, id_valid, id_stall}); end
        n_cmp++;
        if (id_pc !== 32'h300) begin n_err++; $display("FAIL flush_nocapture: id_pc=%h want 300", id_pc); end
    endtask

    task automatic test_csr();
        offer(32'h3402D073, 32'h500, 1'b1);
        @(negedge clk);
        if_valid = 1'b0;
        #1;
`ifdef ID_CSR_SERIALIZE_EN
        for (int i = 0; i < CSR_DRAIN; i++) begin
            n_cmp++;
            if ({id_valid, id_stall} !== 2'b01) begin n_err++; $display("FAIL csr_drain%0d: got v/s=%b want 01", i, {id_valid, id_stall}); end
            @(negedge clk);
            #1;
        end
`endif
        n_cmp++;
        if ({id_valid, id_stall, id_imm_src} !== 5'b10_101) begin
            n_err++; $display("FAIL csr_issue: got v/s/imm=%b want 10101", {id_valid, id_stall, id_imm_src});
        end
        @(negedge clk);
        idle_inputs();
        #1;
        n_cmp++;
        if (id_valid !== 1'b0) begin n_err++; $display("FAIL csr_done: id_valid=%b want 0", id_valid); end
    endtask

    task automatic test_reset_in_stall();
        offer(32'h002081B3, 32'h600, 1'b1);
        @(negedge clk);
        if_valid = 1'b0; ex_is_load = 1'b1; ex_rd = 5'd1;
        @(negedge clk);
        ex_is_load = 1'b0;
        #1;
        n_cmp++;
        if ({id_valid, id_stall} !== 2'b01) begin n_err++; $display("FAIL rst_stall_pre: got v/s=%b want 01", {id_valid, id_stall}); end
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({if_ready, id_valid, id_stall, id_illegal, id_instr, id_pc, id_imm_src} !== {4'b1000, 32'h13, 32'h0, 3'b000}) begin
            n_err++; $display("FAIL rst_stall_force: got flags=%b instr=%h pc=%h imm=%b",
                              {if_ready, id_valid, id_stall, id_illegal}, id_instr, id_pc, id_imm_src);
        end
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        n_cmp++;
        if ({if_ready, id_valid, id_stall} !== 3'b100) begin n_err++; $display("FAIL rst_stall_release: got r/v/s=%b want 100", {if_ready, id_valid, id_stall}); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] e;
        @(negedge clk);
        id_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if_valid = 1'b1;
            if_instr = 32'h00000013 | (32'(i) << 7);
            if_pc    = 32'h1000 + 32'(4 * i);
            #1;
            if (i > 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if ({id_valid, if_ready, id_pc} !== {2'b11, e}) begin
                    n_err++; $display("FAIL b2b_%0d: got v/r=%b pc=%h want 11/%h", i, {id_valid, if_ready}, id_pc, e);
                end
            end
            exp_q.push_back(if_pc);
            @(negedge clk);
        end
        if_valid = 1'b0;
        #1;
        e = exp_q.pop_front();
        n_cmp++;
        if ({id_valid, id_pc} !== {1'b1, e}) begin n_err++; $display("FAIL b2b_last: got v=%b pc=%h want 1/%h", id_valid, id_pc, e); end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_random(input int cycles);
        bit occ, stl, hz, ev, es, er;
        int drain;
        logic [31:0] mi, mp;
        occ = 0; stl = 0; drain = 0; mi = 0; mp = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            flush      = ($urandom_range(0, 19) == 0);
            if_valid   = ($urandom_range(0, 9) < 6);
            id_ready   = ($urandom_range(0, 9) < 6);
            ex_is_load = 1'($urandom_range(0, 1));
            ex_rd      = 5'($urandom_range(0, 3));
            if_instr   = rand_instr();
            if_pc      = $urandom();
            #1;
            hz = occ && !stl && drain == 0 && m_hazard(mi, ex_is_load, ex_rd);
            ev = occ && !stl && drain == 0 && !hz && !flush;
            es = occ && (stl || drain > 0 || hz);
            er = !flush && (!occ || (ev && id_ready));
            n_cmp++;
            if ({if_ready, id_valid, id_stall} !== {er, ev, es}) begin
                n_err++; $display("FAIL rnd_hs c=%0d: got r/v/s=%b want %b", c, {if_ready, id_valid, id_stall}, {er, ev, es});
            end
            if (occ) begin
                n_cmp++;
                if ({id_instr, id_pc, id_imm_src, id_illegal} !== {mi, mp, m_imm(mi), m_illegal(mi)}) begin
                    n_err++; $display("FAIL rnd_data c=%0d: got %h/%h/%b/%b want %h/%h/%b/%b", c, id_instr, id_pc,
                                      id_imm_src, id_illegal, mi, mp, m_imm(mi), m_illegal(mi));
                end
            end
            @(posedge clk);
            if (flush) begin
                occ = 0; stl = 0; drain = 0;
            end else if (stl) begin
                stl = 0;
            end else if (drain > 0) begin
                drain--;
            end else if (hz) begin
                stl = 1;
            end else begin
                if (ev && id_ready) occ = 0;
                if (er && if_valid) begin
                    occ = 1; mi = if_instr; mp = if_pc;
`ifdef ID_CSR_SERIALIZE_EN
                    drain = (if_instr[6:0] == 7'h73) ? CSR_DRAIN : 0;
`endif
                end
            end
        end
        clear_pipe();
    endtask

    initial begin
        test_reset();
        test_addi();
        test_load_use(5'd2);
        test_load_use(5'd0);
        test_flush();
        test_csr();
        test_back_to_back();
        test_reset_in_stall();
        clear_pipe();
        test_random(800);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
